// File: rtl/evm_pkg.sv
// Shared types and helpers for the EVM ballot sequencer.
package evm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COMMIT,
        LOCKOUT
    } state_t;

    localparam int DEF_NUM_CAND = 4;
    localparam int DEF_CNT_W    = 16;

    // Counters up to 32 bits wide go through this; callers pass their all-ones ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/vote_controller_if.sv
// Officer/candidate inputs and tally/status outputs of the ballot sequencer.
interface vote_controller_if #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 16
);
    localparam int SEL_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

    logic                mode;
    logic                ballot_enable;
    logic [NUM_CAND-1:0] cand_vote;
    logic [SEL_W-1:0]    result_sel;
    logic                armed;
    logic                vote_ack;
    logic                vote_reject;
    logic                timeout;
    logic [CNT_W-1:0]    result_count;
    logic [CNT_W-1:0]    total_votes;

    modport master (
        output mode, ballot_enable, cand_vote, result_sel,
        input  armed, vote_ack, vote_reject, timeout, result_count, total_votes
    );

    modport slave (
        input  mode, ballot_enable, cand_vote, result_sel,
        output armed, vote_ack, vote_reject, timeout, result_count, total_votes
    );
endinterface

// File: rtl/vote_tally_bank.sv
// Per-candidate saturating tallies, saturating grand total and registered read mux.
module vote_tally_bank
    import evm_pkg::*;
#(
    parameter int NUM_CAND = DEF_NUM_CAND,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int SEL_W    = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic [SEL_W-1:0] inc_idx,
    input  logic             rd_en,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic [CNT_W-1:0] total
);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] tally [NUM_CAND];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) tally[i] <= '0;
            total   <= '0;
            rd_data <= '0;
        end else begin
            if (inc) begin
                tally[inc_idx] <= CNT_W'(sat_inc(32'(tally[inc_idx]), 32'(MAX)));
                total          <= CNT_W'(sat_inc(32'(total), 32'(MAX)));
            end
            if (rd_en && (32'(rd_sel) < 32'(NUM_CAND)))
                rd_data <= tally[rd_sel];
            else
                rd_data <= '0;
        end
    end
endmodule

// File: rtl/vote_controller.sv
// Ballot sequencer: arms one ballot per officer enable edge, commits one vote, then locks out.
module vote_controller
    import evm_pkg::*;
#(
    parameter int NUM_CAND    = DEF_NUM_CAND,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = 1000,
    parameter int LOCKOUT_CYC = 20
) (
    input  logic              clock,
    input  logic              reset_n,
    vote_controller_if.slave  bus
);
    localparam int SEL_W = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
    localparam int TMR_W = $clog2((TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC) + 1;

    state_t           state, state_nx;
    logic             be_q;
    logic [TMR_W-1:0] timer;
    logic [SEL_W-1:0] idx_q, hit_idx;
    logic             reject_q, timeout_q;
    logic             timer_clr, latch, reject_nx, timeout_nx, armed_c, ack_c;
    logic             rise;
    int unsigned      pop;

    assign rise = bus.ballot_enable & ~be_q;

    always_comb begin
        pop     = 0;
        hit_idx = '0;
        for (int unsigned i = 0; i < NUM_CAND; i++) begin
            if (bus.cand_vote[i]) begin
                pop++;
                hit_idx = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        armed_c    = 1'b0;
        ack_c      = 1'b0;
        timer_clr  = 1'b0;
        latch      = 1'b0;
        reject_nx  = 1'b0;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                if (!bus.mode && rise) state_nx = ARMED;
            end
            ARMED: begin
                armed_c = 1'b1;
                // Abort beats everything; an accepted vote beats an expiring timer.
                if (bus.mode) begin
                    state_nx = IDLE;
                end else if (pop == 1) begin
                    latch    = 1'b1;
                    state_nx = COMMIT;
                end else begin
                    reject_nx = (pop > 1);
                    if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                        timeout_nx = 1'b1;
                        state_nx   = IDLE;
                    end
                end
            end
            COMMIT: begin
                ack_c     = 1'b1;
                timer_clr = 1'b1;
                state_nx  = LOCKOUT;
            end
            LOCKOUT: begin
                if (timer == TMR_W'(LOCKOUT_CYC - 1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            be_q      <= 1'b0;
            timer     <= '0;
            idx_q     <= '0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            be_q      <= bus.ballot_enable;
            timer     <= timer_clr ? '0 : timer + TMR_W'(1);
            if (latch) idx_q <= hit_idx;
            reject_q  <= reject_nx;
            timeout_q <= timeout_nx;
        end
    end

    vote_tally_bank #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W),
        .SEL_W    (SEL_W)
    ) u_bank (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (ack_c),
        .inc_idx (idx_q),
        .rd_en   (bus.mode),
        .rd_sel  (bus.result_sel),
        .rd_data (bus.result_count),
        .total   (bus.total_votes)
    );

    assign bus.armed       = armed_c;
    assign bus.vote_ack    = ack_c;
    assign bus.vote_reject = reject_q;
    assign bus.timeout     = timeout_q;
endmodule
